// File: rtl/muldiv_seq_pkg.sv
// Shared types and constants for the iterative multiply/divide sequencer.
// Exports op encodings, the FSM state enum, the step-counter width and op helpers.
package md_pkg;

   localparam logic [1:0] MD_MULT  = 2'b00;
   localparam logic [1:0] MD_MULTU = 2'b01;
   localparam logic [1:0] MD_DIV   = 2'b10;
   localparam logic [1:0] MD_DIVU  = 2'b11;

   localparam int CNT_W = 6;

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_FIX,
      S_DONE
   } md_state_t;

   function automatic logic op_is_div(input logic [1:0] op);
      return op[1];
   endfunction

   function automatic logic op_is_signed(input logic [1:0] op);
      return ~op[0];
   endfunction

endpackage

// File: rtl/muldiv_seq_if.sv
// CPU <-> multiply/divide unit bundle.
// master: controller drives op/operands/hilo hints; slave: unit drives stall, busy, hi/lo writes.
interface muldiv_seq_if #(
   parameter int WIDTH = 32
);

   logic             op_valid;
   logic [1:0]       op;
   logic [WIDTH-1:0] rs_data;
   logic [WIDTH-1:0] rt_data;
   logic             hilo_rd;
   logic             hilo_wr;
   logic             stall;
   logic             busy;
   logic             hi_we;
   logic             lo_we;
   logic [WIDTH-1:0] hi_wdata;
   logic [WIDTH-1:0] lo_wdata;
   logic             div_zero;

   modport master (
      output op_valid, op, rs_data, rt_data, hilo_rd, hilo_wr,
      input  stall, busy, hi_we, lo_we, hi_wdata, lo_wdata, div_zero
   );

   modport slave (
      input  op_valid, op, rs_data, rt_data, hilo_rd, hilo_wr,
      output stall, busy, hi_we, lo_we, hi_wdata, lo_wdata, div_zero
   );

endinterface

// File: rtl/muldiv_seq_step.sv
// One combinational iteration: MSB-first shift-add (multiply) or restoring shift-subtract (divide).
// Ports: i_acc {hi,lo} accumulator, i_opnd multiplicand/divisor, i_bit next operand bit, i_div mode, o_acc next value.
module md_step #(
   parameter int WIDTH = 32
) (
   input  logic [2*WIDTH-1:0] i_acc,
   input  logic [WIDTH-1:0]   i_opnd,
   input  logic               i_bit,
   input  logic               i_div,
   output logic [2*WIDTH-1:0] o_acc
);

   logic [WIDTH:0] w_rem_sh;
   logic           w_ge;

   always_comb begin
      w_rem_sh = {i_acc[2*WIDTH-1:WIDTH], i_bit};
      w_ge     = (w_rem_sh >= {1'b0, i_opnd});
      o_acc    = {i_acc[2*WIDTH-2:0], 1'b0};
      if (i_div) begin
         // remainder in hi gets the next dividend bit; quotient bit enters lo
         o_acc[2*WIDTH-1:WIDTH] = w_ge ?
            WIDTH'(w_rem_sh - {1'b0, i_opnd}) : w_rem_sh[WIDTH-1:0];
         o_acc[WIDTH-1:0] = {i_acc[WIDTH-2:0], w_ge};
      end else if (i_bit) begin
         o_acc = {i_acc[2*WIDTH-2:0], 1'b0} + {{WIDTH{1'b0}}, i_opnd};
      end
   end

endmodule

// File: rtl/muldiv_seq.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer feeding the hi/lo registers.
// Ports: clk, reset (sync, active-low), bus (muldiv_seq_if.slave) carrying issue, stall and hi/lo write strobes.
module muldiv_seq
   import md_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic       clk,
   input  logic       reset,
   muldiv_seq_if.slave bus
);

   md_state_t          r_state;
   md_state_t          w_nxt;
   logic [CNT_W-1:0]   r_cnt;
   logic               r_div;
   logic               r_neg_q;
   logic               r_neg_r;
   logic               r_dz;
   logic [WIDTH-1:0]   r_opnd;
   logic [WIDTH-1:0]   r_sh;
   logic [2*WIDTH-1:0] r_acc;

   logic               w_sgn;
   logic               w_isdiv;
   logic               w_dz;
   logic               w_issue;
   logic [WIDTH-1:0]   w_rs_mag;
   logic [WIDTH-1:0]   w_rt_mag;
   logic [2*WIDTH-1:0] w_step;
   logic               w_rs_msb;
   logic               w_rt_msb;

   assign w_sgn    = op_is_signed(bus.op);
   assign w_isdiv  = op_is_div(bus.op);
   assign w_rs_msb = bus.rs_data[WIDTH-1];
   assign w_rt_msb = bus.rt_data[WIDTH-1];
   assign w_rs_mag = (w_sgn & w_rs_msb) ? -bus.rs_data : bus.rs_data;
   assign w_rt_mag = (w_sgn & w_rt_msb) ? -bus.rt_data : bus.rt_data;
   assign w_dz     = w_isdiv & (bus.rt_data == '0);
   assign w_issue  = (r_state == S_IDLE) & bus.op_valid;

   md_step #(.WIDTH(WIDTH)) u_step (
      .i_acc  (r_acc),
      .i_opnd (r_opnd),
      .i_bit  (r_sh[WIDTH-1]),
      .i_div  (r_div),
      .o_acc  (w_step)
   );

   always_ff @(posedge clk) begin
      if (!reset) r_state <= S_IDLE;
      else        r_state <= w_nxt;
   end

   always_comb begin
      w_nxt = r_state;
      unique case (r_state)
         S_IDLE: if (bus.op_valid) w_nxt = w_dz ? S_DONE : S_RUN;
         S_RUN:  if (r_cnt == CNT_W'(WIDTH-1)) w_nxt = S_FIX;
         S_FIX:  w_nxt = S_DONE;
         S_DONE: w_nxt = S_IDLE;
         default: w_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_cnt   <= '0;
         r_div   <= 1'b0;
         r_neg_q <= 1'b0;
         r_neg_r <= 1'b0;
         r_dz    <= 1'b0;
         r_opnd  <= '0;
         r_sh    <= '0;
         r_acc   <= '0;
      end else if (w_issue) begin
         r_cnt   <= '0;
         r_div   <= w_isdiv;
         r_neg_q <= w_sgn & (w_rs_msb ^ w_rt_msb);
         r_neg_r <= w_sgn & w_rs_msb;
         r_dz    <= w_dz;
         // r_sh is consumed MSB-first: multiplier bits or dividend bits
         r_opnd  <= w_isdiv ? w_rt_mag : w_rs_mag;
         r_sh    <= w_isdiv ? w_rs_mag : w_rt_mag;
         r_acc   <= w_dz ? {bus.rs_data, {WIDTH{1'b1}}} : '0;
      end else if (r_state == S_RUN) begin
         r_acc <= w_step;
         r_sh  <= r_sh << 1;
         r_cnt <= r_cnt + 1'b1;
      end else if (r_state == S_FIX) begin
         if (!r_div) begin
            if (r_neg_q) r_acc <= -r_acc;
         end else begin
            if (r_neg_r) r_acc[2*WIDTH-1:WIDTH] <= -r_acc[2*WIDTH-1:WIDTH];
            if (r_neg_q) r_acc[WIDTH-1:0] <= -r_acc[WIDTH-1:0];
         end
      end
   end

   assign bus.busy     = (r_state != S_IDLE);
   assign bus.stall    = (bus.op_valid | bus.hilo_rd | bus.hilo_wr) & bus.busy;
   assign bus.hi_we    = (r_state == S_DONE);
   assign bus.lo_we    = (r_state == S_DONE);
   assign bus.hi_wdata = bus.hi_we ? r_acc[2*WIDTH-1:WIDTH] : '0;
   assign bus.lo_wdata = bus.lo_we ? r_acc[WIDTH-1:0] : '0;
   assign bus.div_zero = bus.hi_we & r_dz;

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: directed corner cases plus random ops vs an arithmetic model.
// Drives inputs #1 after posedge, samples outputs on negedge.
module tb_muldiv_seq;
   import md_pkg::*;

   localparam int W = 32;

   logic clk = 1'b0;
   logic reset;
   int   n_tests = 0;
   int   n_fail  = 0;

   always #5 clk = ~clk;

   muldiv_seq_if #(.WIDTH(W)) ifc ();

   muldiv_seq #(.WIDTH(W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (ifc)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] ref_md(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
      longint sa, sb, q, r;
      logic [63:0] p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      p  = '0;
      case (op)
         MD_MULT:  p = 64'(sa * sb);
         MD_MULTU: p = {32'b0, a} * {32'b0, b};
         MD_DIV: begin
            if (b == 0) p = {a, 32'hFFFFFFFF};
            else begin
               q = sa / sb;
               r = sa % sb;
               p = {r[31:0], q[31:0]};
            end
         end
         default: begin
            if (b == 0) p = {a, 32'hFFFFFFFF};
            else p = {a % b, a / b};
         end
      endcase
      return p;
   endfunction

   task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      int k;
      logic [63:0] e;
      logic dz;
      e  = ref_md(op, a, b);
      dz = op[1] && (b == 0);
      @(posedge clk); #1;
      ifc.op_valid = 1'b1;
      ifc.op = op;
      ifc.rs_data = a;
      ifc.rt_data = b;
      @(negedge clk);
      chk("issue_stall", {63'b0, ifc.stall}, 64'd0);
      @(posedge clk); #1;
      ifc.op_valid = 1'b0;
      ifc.rs_data = $urandom;
      ifc.rt_data = $urandom;
      k = 1;
      @(negedge clk);
      while (!ifc.hi_we && k < 60) begin
         @(negedge clk);
         k++;
      end
      chk("latency", 64'(k), dz ? 64'd1 : 64'd34);
      chk("result", {ifc.hi_wdata, ifc.lo_wdata}, e);
      chk("lo_we", {63'b0, ifc.lo_we}, 64'd1);
      chk("div_zero", {63'b0, ifc.div_zero}, {63'b0, dz});
      @(negedge clk);
      chk("post_idle", {62'b0, ifc.busy, ifc.hi_we}, 64'd0);
   endtask

   function automatic logic [31:0] pick();
      logic [31:0] t [5];
      t[0] = 32'h0;
      t[1] = 32'h1;
      t[2] = 32'hFFFFFFFF;
      t[3] = 32'h80000000;
      t[4] = 32'h7FFFFFFF;
      if ($urandom_range(0, 3) == 0) return t[$urandom_range(0, 4)];
      return $urandom;
   endfunction

   initial begin
      int n, wr, nst, nw, cyc;
      logic acc_d;
      logic [1:0] op;
      logic [31:0] a, b, a2, b2;
      logic [63:0] got [2];
      ifc.op_valid = 1'b0;
      ifc.op = 2'b00;
      ifc.rs_data = '0;
      ifc.rt_data = '0;
      ifc.hilo_rd = 1'b0;
      ifc.hilo_wr = 1'b0;
      reset = 1'b0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b1;
      ifc.hilo_rd = 1'b1;
      @(negedge clk);
      chk("rst_outs", {ifc.stall, ifc.busy, ifc.hi_we, ifc.lo_we, ifc.div_zero,
                       ifc.hi_wdata, ifc.lo_wdata}, 64'd0);
      @(posedge clk); #1 ifc.hilo_rd = 1'b0;

      do_op(MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
      do_op(MD_DIV, 32'hFFFFFFF9, 32'd2);
      do_op(MD_DIV, 32'h80000000, 32'hFFFFFFFF);
      do_op(MD_DIVU, 32'd5, 32'd0);
      do_op(MD_DIV, 32'd5, 32'd0);
      do_op(MD_MULT, 32'h80000000, 32'h80000000);

      // independent instructions flow; MFLO waits for the write
      a = $urandom;
      b = $urandom;
      @(posedge clk); #1;
      ifc.op_valid = 1'b1;
      ifc.op = MD_MULT;
      ifc.rs_data = a;
      ifc.rt_data = b;
      @(negedge clk);
      chk("mult_issue_stall", {63'b0, ifc.stall}, 64'd0);
      for (int i = 1; i <= 3; i++) begin
         @(posedge clk); #1 ifc.op_valid = 1'b0;
         @(negedge clk);
         chk("alu_stall", {62'b0, ifc.stall, ifc.busy}, 64'd1);
      end
      @(posedge clk); #1 ifc.hilo_rd = 1'b1;
      n = 0;
      wr = 0;
      got[0] = '0;
      @(negedge clk);
      while (ifc.stall && n < 60) begin
         if (ifc.hi_we) begin
            got[0] = {ifc.hi_wdata, ifc.lo_wdata};
            wr++;
         end
         n++;
         @(negedge clk);
      end
      chk("mflo_stall_cycles", 64'(n), 64'd31);
      chk("mflo_writes", 64'(wr), 64'd1);
      chk("mflo_result", got[0], ref_md(MD_MULT, a, b));
      @(posedge clk); #1 ifc.hilo_rd = 1'b0;

      // reset mid-operation aborts without a write
      @(posedge clk); #1;
      ifc.op_valid = 1'b1;
      ifc.op = MD_MULT;
      ifc.rs_data = 32'hFFFFFFFD;
      ifc.rt_data = 32'd4;
      @(posedge clk); #1 ifc.op_valid = 1'b0;
      repeat (9) @(posedge clk);
      #1 reset = 1'b0;
      @(posedge clk); #1 reset = 1'b1;
      @(negedge clk);
      chk("midrst_outs", {ifc.stall, ifc.busy, ifc.hi_we, ifc.lo_we, ifc.div_zero,
                          ifc.hi_wdata, ifc.lo_wdata}, 64'd0);
      n = 0;
      repeat (40) begin
         @(negedge clk);
         if (ifc.hi_we || ifc.lo_we) n++;
      end
      chk("midrst_no_write", 64'(n), 64'd0);
      do_op(MD_MULT, 32'hFFFFFFFD, 32'd4);

      // back-to-back DIVU, second held while busy
      a  = $urandom;
      b  = $urandom | 32'h1;
      a2 = $urandom;
      b2 = ($urandom & 32'hFFFF) | 32'h1;
      @(posedge clk); #1;
      ifc.op_valid = 1'b1;
      ifc.op = MD_DIVU;
      ifc.rs_data = a;
      ifc.rt_data = b;
      @(posedge clk); #1;
      ifc.rs_data = a2;
      ifc.rt_data = b2;
      nst = 0;
      nw = 0;
      cyc = 0;
      acc_d = 1'b0;
      got[0] = '0;
      got[1] = '0;
      while (nw < 2 && cyc < 200) begin
         @(negedge clk);
         if (ifc.hi_we) begin
            got[nw] = {ifc.hi_wdata, ifc.lo_wdata};
            nw++;
         end
         if (ifc.op_valid) begin
            if (ifc.stall) nst++;
            else acc_d = 1'b1;
         end
         @(posedge clk); #1;
         if (acc_d) ifc.op_valid = 1'b0;
         cyc++;
      end
      chk("b2b_stalls", 64'(nst), 64'd34);
      chk("b2b_writes", 64'(nw), 64'd2);
      chk("b2b_first", got[0], ref_md(MD_DIVU, a, b));
      chk("b2b_second", got[1], ref_md(MD_DIVU, a2, b2));

      for (int i = 0; i < 40; i++) begin
         op = 2'($urandom_range(0, 3));
         a  = pick();
         b  = pick();
         if (op == MD_DIV && b == 0) b = 32'd1;
         do_op(op, a, b);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
